// File: rtl/nice_cordic_pkg.sv
// Shared types and timing constants for the CORDIC scheduler and its core.
`timescale 1ns/1ps
package nice_cordic_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT
    } sched_state_e;

    typedef enum logic [1:0] {
        C_IDLE,
        C_PRE,
        C_ITER,
        C_DONE
    } core_state_e;

    localparam int BIT_WIDTH_IN_DEFAULT = 24;
    localparam int PI_DEFAULT           = 8388607;
    localparam int CORDIC_LATENCY       = BIT_WIDTH_IN_DEFAULT + 2;

    // Extra fractional bits carried in the core's x/y path to keep
    // shift truncation from eroding the radius.
    localparam int ROUND_GUARD_BITS = 2;

    // Cycles from start to done_o for a core of the given width.
    function automatic int cordic_latency(input int bit_width_in);
        return bit_width_in + 2;
    endfunction

    // Cycles after start at which a missing done_o is given up on.
    function automatic int watchdog_limit(input int bit_width_in);
        return cordic_latency(bit_width_in) + 6;
    endfunction

endpackage

// File: rtl/cordic_scheduler_core.sv
// Iterative vectoring CORDIC: (x=sin_i, y=cos_i) -> phase atan2(y,x) and
// gain-scaled radius. One iteration per cycle after a pre-rotation step
// that folds the left half-plane onto the right (+-PI offset).
`timescale 1ns/1ps
module CordicFSM
    import nice_cordic_pkg::*;
#(
    parameter int BIT_WIDTH_IN  = 24,
    parameter int BIT_WIDTH_OUT = 26,
    parameter int PI            = PI_DEFAULT
) (
    input  logic                                      clk_i,
    input  logic                                      reset_i,
    input  logic                                      start_i,
    input  logic [BIT_WIDTH_IN-1:0]                   sin_i,
    input  logic [BIT_WIDTH_IN-1:0]                   cos_i,
    input  logic [BIT_WIDTH_IN-1:0][BIT_WIDTH_IN-1:0] angle_table_i,
    output logic                                      done_o,
    output logic signed [BIT_WIDTH_OUT-1:0]           phi_o,
    output logic signed [BIT_WIDTH_IN:0]              r_o
);

    localparam int G  = ROUND_GUARD_BITS;
    localparam int XW = BIT_WIDTH_IN + 2 + G;
    localparam int IW = $clog2(BIT_WIDTH_IN);
    localparam logic signed [BIT_WIDTH_OUT-1:0] PI_Z      = BIT_WIDTH_OUT'(PI);
    localparam logic        [IW-1:0]            LAST_ITER = IW'(BIT_WIDTH_IN - 1);
    localparam logic signed [XW-1:0]            HALF_LSB  = XW'(2 ** (G - 1));

    core_state_e st_q, st_d;

    logic signed [XW-1:0]            x_q, y_q;
    logic signed [XW-1:0]            x_sh, y_sh, x_rnd;
    logic signed [BIT_WIDTH_OUT-1:0] z_q, ang;
    logic        [IW-1:0]            iter_q;
    logic                            unused_bits;

    assign x_sh  = x_q >>> iter_q;
    assign y_sh  = y_q >>> iter_q;
    assign ang   = {{(BIT_WIDTH_OUT - BIT_WIDTH_IN){angle_table_i[iter_q][BIT_WIDTH_IN-1]}},
                    angle_table_i[iter_q]};
    assign x_rnd = x_q + HALF_LSB;

    assign done_o      = (st_q == C_DONE);
    assign phi_o       = z_q;
    assign r_o         = x_rnd[G +: BIT_WIDTH_IN + 1];
    assign unused_bits = ^{x_rnd[XW-1], x_rnd[G-1:0]};

    // Core state register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) st_q <= C_IDLE;
        else         st_q <= st_d;
    end

    // Core sequencing: start -> pre-rotate -> BIT_WIDTH_IN iterations -> done.
    always_comb begin
        st_d = st_q;
        unique case (st_q)
            C_IDLE:  if (start_i) st_d = C_PRE;
            C_PRE:   st_d = C_ITER;
            C_ITER:  if (iter_q == LAST_ITER) st_d = C_DONE;
            C_DONE:  st_d = C_IDLE;
            default: st_d = C_IDLE;
        endcase
    end

    // x/y/z datapath; operands are captured only on start in idle.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            iter_q <= '0;
        end else begin
            unique case (st_q)
                C_IDLE: begin
                    if (start_i) begin
                        x_q    <= {{(XW - BIT_WIDTH_IN - G){sin_i[BIT_WIDTH_IN-1]}}, sin_i, {G{1'b0}}};
                        y_q    <= {{(XW - BIT_WIDTH_IN - G){cos_i[BIT_WIDTH_IN-1]}}, cos_i, {G{1'b0}}};
                        z_q    <= '0;
                        iter_q <= '0;
                    end
                end
                C_PRE: begin
                    if (x_q[XW-1]) begin
                        x_q <= -x_q;
                        y_q <= -y_q;
                        z_q <= y_q[XW-1] ? -PI_Z : PI_Z;
                    end
                end
                C_ITER: begin
                    if (!y_q[XW-1]) begin
                        x_q <= x_q + y_sh;
                        y_q <= y_q - x_sh;
                        z_q <= z_q + ang;
                    end else begin
                        x_q <= x_q - y_sh;
                        y_q <= y_q + x_sh;
                        z_q <= z_q - ang;
                    end
                    iter_q <= iter_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/cordic_scheduler_rr_arbiter.sv
// Round-robin picker: first pending channel at or after rr_ptr, wrapping.
// Purely combinational; the pointer itself lives in the scheduler.
`timescale 1ns/1ps
module rr_arbiter #(
    parameter int N_CH = 4
) (
    input  logic [N_CH-1:0]         pend,
    input  logic [$clog2(N_CH)-1:0] rr_ptr,
    output logic [$clog2(N_CH)-1:0] grant,
    output logic                    any_grant
);

    localparam int CH_W = $clog2(N_CH);

    logic            hi_found;
    logic [CH_W-1:0] hi_idx;
    logic [CH_W-1:0] lo_idx;

    // Descending scan so the last hit is the lowest index: hi_* is the
    // lowest pending channel >= rr_ptr, lo_* the lowest overall (wrap case).
    always_comb begin
        hi_found  = 1'b0;
        hi_idx    = '0;
        lo_idx    = '0;
        any_grant = 1'b0;
        for (int c = N_CH - 1; c >= 0; c--) begin
            if (pend[c]) begin
                any_grant = 1'b1;
                lo_idx    = CH_W'(c);
                if (CH_W'(c) >= rr_ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = CH_W'(c);
                end
            end
        end
        grant = hi_found ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/cordic_scheduler.sv
// Time-shares one CORDIC core between N_CH channels. Each channel has a
// one-deep pending buffer (newest sample wins); a round-robin arbiter picks
// the next channel whenever the scheduler is idle. Results come back tagged
// with the channel index.
//
//  state   | meaning
//  S_IDLE  | no op in flight; latch the winner's operands if anything pends
//  S_START | one-cycle start pulse to the core, operands held stable
//  S_WAIT  | wait for done_o (or watchdog expiry), then back to idle
`timescale 1ns/1ps
module cordic_scheduler
    import nice_cordic_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int BIT_WIDTH_IN  = 24,
    parameter int BIT_WIDTH_OUT = 26,
    parameter int PI            = PI_DEFAULT
) (
    input  logic                                      clk_i,
    input  logic                                      reset_ni,
    input  logic [N_CH-1:0]                           sample_valid_i,
    input  logic [N_CH-1:0][BIT_WIDTH_IN-1:0]         sin_i,
    input  logic [N_CH-1:0][BIT_WIDTH_IN-1:0]         cos_i,
    input  logic [BIT_WIDTH_IN-1:0][BIT_WIDTH_IN-1:0] angle_table_i,
    input  logic                                      clear_overrun_i,
    output logic                                      result_valid_o,
    output logic [$clog2(N_CH)-1:0]                   result_ch_o,
    output logic signed [BIT_WIDTH_OUT-1:0]           phi_o,
    output logic signed [BIT_WIDTH_IN:0]              r_o,
    output logic [N_CH-1:0]                           overrun_o,
    output logic                                      busy_o
);

    localparam int CH_W = $clog2(N_CH);
    localparam int WD_W = $clog2(BIT_WIDTH_IN + 9);
    // Counter reaches zero exactly watchdog_limit cycles after the start cycle.
    localparam logic [WD_W-1:0] WD_LOAD  = WD_W'(watchdog_limit(BIT_WIDTH_IN) - 1);
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(N_CH - 1);

    sched_state_e state_q, state_d;

    logic [N_CH-1:0]                   pend_q;
    logic [N_CH-1:0]                   granted;
    logic [N_CH-1:0]                   overrun_set;
    logic [N_CH-1:0][BIT_WIDTH_IN-1:0] hold_sin_q, hold_cos_q;
    logic [BIT_WIDTH_IN-1:0]           op_sin_q, op_cos_q;
    logic [CH_W-1:0]                   op_ch_q, rr_ptr_q, grant_idx;
    logic [WD_W-1:0]                   wd_cnt_q;
    logic                              any_grant, take;
    logic                              core_reset, core_start, core_done, wd_expired;
    logic signed [BIT_WIDTH_OUT-1:0]   core_phi;
    logic signed [BIT_WIDTH_IN:0]      core_r;

    rr_arbiter #(
        .N_CH (N_CH)
    ) u_arb (
        .pend      (pend_q),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant_idx),
        .any_grant (any_grant)
    );

    assign core_reset = ~reset_ni;

    CordicFSM #(
        .BIT_WIDTH_IN  (BIT_WIDTH_IN),
        .BIT_WIDTH_OUT (BIT_WIDTH_OUT),
        .PI            (PI)
    ) u_core (
        .clk_i         (clk_i),
        .reset_i       (core_reset),
        .start_i       (core_start),
        .sin_i         (op_sin_q),
        .cos_i         (op_cos_q),
        .angle_table_i (angle_table_i),
        .done_o        (core_done),
        .phi_o         (core_phi),
        .r_o           (core_r)
    );

    assign take        = (state_q == S_IDLE) && any_grant;
    assign wd_expired  = (state_q == S_WAIT) && (wd_cnt_q == '0);
    assign overrun_set = sample_valid_i & pend_q & ~granted;
    assign busy_o      = (state_q != S_IDLE);

    // One-hot of the channel whose buffer is handed to the core this cycle.
    always_comb begin
        granted = '0;
        for (int c = 0; c < N_CH; c++) begin
            granted[c] = take && (grant_idx == CH_W'(c));
        end
    end

    // Pending buffers; a strobe in the grant cycle re-arms pend, since the
    // core takes the old buffer contents and the new sample must wait.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            pend_q     <= '0;
            hold_sin_q <= '0;
            hold_cos_q <= '0;
            overrun_o  <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (sample_valid_i[c]) begin
                    hold_sin_q[c] <= sin_i[c];
                    hold_cos_q[c] <= cos_i[c];
                end
            end
            pend_q    <= sample_valid_i | (pend_q & ~granted);
            overrun_o <= overrun_set | (overrun_o & {N_CH{~clear_overrun_i}});
        end
    end

    // Scheduler state register.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    // Next state and the core start pulse.
    always_comb begin
        state_d    = state_q;
        core_start = 1'b0;
        unique case (state_q)
            S_IDLE:  if (any_grant) state_d = S_START;
            S_START: begin
                core_start = 1'b1;
                state_d    = S_WAIT;
            end
            S_WAIT:  if (core_done || wd_expired) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operand latch and round-robin pointer advance on each grant.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            op_sin_q <= '0;
            op_cos_q <= '0;
            op_ch_q  <= '0;
            rr_ptr_q <= '0;
        end else if (take) begin
            op_sin_q <= hold_sin_q[grant_idx];
            op_cos_q <= hold_cos_q[grant_idx];
            op_ch_q  <= grant_idx;
            rr_ptr_q <= (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
        end
    end

    // Watchdog down-counter, armed in the start cycle.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wd_cnt_q <= '0;
        end else if (state_q == S_START) begin
            wd_cnt_q <= WD_LOAD;
        end else if ((state_q == S_WAIT) && (wd_cnt_q != '0)) begin
            wd_cnt_q <= wd_cnt_q - 1'b1;
        end
    end

    // Result register: one-cycle valid per completed op, data held after.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            result_valid_o <= 1'b0;
            result_ch_o    <= '0;
            phi_o          <= '0;
            r_o            <= '0;
        end else begin
            result_valid_o <= (state_q == S_WAIT) && core_done;
            if ((state_q == S_WAIT) && core_done) begin
                result_ch_o <= op_ch_q;
                phi_o       <= core_phi;
                r_o         <= core_r;
            end
        end
    end

endmodule

// File: tb/tb_cordic_scheduler.sv
// Directed bench for cordic_scheduler: latency, round-robin order,
// overrun handling, grant-cycle re-strobe, left half-plane and reset.
`timescale 1ns/1ps
module tb_cordic_scheduler;

    localparam real PI_R  = 3.14159265358979323846;
    localparam real SCALE = 8388607.0 / PI_R;

    logic                   clk = 1'b0;
    logic                   reset_ni = 1'b0;
    logic [3:0]             sample_valid = '0;
    logic [3:0][23:0]       sin_v = '0;
    logic [3:0][23:0]       cos_v = '0;
    logic [23:0][23:0]      angle_table = '0;
    logic                   clear_overrun = 1'b0;
    logic                   result_valid;
    logic [1:0]             result_ch;
    logic signed [25:0]     phi;
    logic signed [24:0]     r;
    logic [3:0]             overrun;
    logic                   busy;

    int     n_total = 0;
    int     n_bad   = 0;
    int     cyc     = 0;
    real    gain_k;
    int     q_ch[$];
    int     q_cyc[$];
    longint q_phi[$];
    longint q_r[$];

    cordic_scheduler dut (
        .clk_i           (clk),
        .reset_ni        (reset_ni),
        .sample_valid_i  (sample_valid),
        .sin_i           (sin_v),
        .cos_i           (cos_v),
        .angle_table_i   (angle_table),
        .clear_overrun_i (clear_overrun),
        .result_valid_o  (result_valid),
        .result_ch_o     (result_ch),
        .phi_o           (phi),
        .r_o             (r),
        .overrun_o       (overrun),
        .busy_o          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (result_valid) begin
            q_ch.push_back(int'(result_ch));
            q_cyc.push_back(cyc);
            q_phi.push_back(longint'(phi));
            q_r.push_back(longint'(r));
        end
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint rnd(input real x);
        return (x >= 0.0) ? longint'($rtoi(x + 0.5)) : -longint'($rtoi(-x + 0.5));
    endfunction

    // Returns e when v is within tol of e, otherwise v itself, so a failed
    // check reports the real observed value.
    function automatic longint near(input longint v, input longint e, input longint tol);
        return ((v - e <= tol) && (e - v <= tol)) ? e : v;
    endfunction

    function automatic longint exp_phi(input real s, input real c);
        return rnd($atan2(c, s) * SCALE);
    endfunction

    function automatic longint exp_r(input real s, input real c);
        return rnd($sqrt(s * s + c * c) * gain_k);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset_ni      = 1'b0;
        sample_valid  = '0;
        clear_overrun = 1'b0;
        @(negedge clk);
        reset_ni = 1'b1;
        @(negedge clk);
        q_ch.delete();
        q_cyc.delete();
        q_phi.delete();
        q_r.delete();
    endtask

    task automatic strobe(input int ch, input int s, input int c, output int t0);
        sample_valid     = '0;
        sample_valid[ch] = 1'b1;
        sin_v[ch]        = 24'(s);
        cos_v[ch]        = 24'(c);
        t0 = cyc;
        @(negedge clk);
        sample_valid = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        int  t0;
        int  t1;
        real p;

        gain_k = 1.0;
        p = 1.0;
        for (int i = 0; i < 24; i++) begin
            angle_table[i] = 24'(rnd($atan(p) * SCALE));
            gain_k = gain_k * $sqrt(1.0 + p * p);
            p = p / 2.0;
        end

        // Reset values
        tick(3);
        chk("rst_valid",   longint'(result_valid), 0);
        chk("rst_busy",    longint'(busy), 0);
        chk("rst_overrun", longint'(overrun), 0);
        chk("rst_phi",     longint'(phi), 0);
        chk("rst_r",       longint'(r), 0);
        chk("rst_ch",      longint'(result_ch), 0);
        reset_ni = 1'b1;
        tick(2);

        // 1: single request on ch2
        q_ch.delete();
        strobe(2, 4000000, 0, t0);
        tick(3);
        chk("t1_busy", longint'(busy), 1);
        tick(40);
        chk("t1_count", q_ch.size(), 1);
        if (q_ch.size() >= 1) begin
            chk("t1_ch",      q_ch[0], 2);
            chk("t1_latency", q_cyc[0] - t0, 29);
            chk("t1_phi",     near(q_phi[0], exp_phi(4000000.0, 0.0), 64), exp_phi(4000000.0, 0.0));
            chk("t1_r",       near(q_r[0], exp_r(4000000.0, 0.0), 64), exp_r(4000000.0, 0.0));
        end
        chk("t1_idle", longint'(busy), 0);

        // 2: all four channels in one cycle, pointer at 0
        do_reset();
        for (int c = 0; c < 4; c++) begin
            sample_valid[c] = 1'b1;
            sin_v[c] = 24'((c + 1) * 1000000);
            cos_v[c] = 24'(c * 1000000);
        end
        t0 = cyc;
        @(negedge clk);
        sample_valid = '0;
        tick(4 * 28 + 30);
        chk("t2_count", q_ch.size(), 4);
        if (q_ch.size() == 4) begin
            chk("t2_latency", q_cyc[0] - t0, 29);
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("t2_ch%0d", k), q_ch[k], k);
                chk($sformatf("t2_phi%0d", k),
                    near(q_phi[k], exp_phi((k + 1) * 1000000.0, k * 1000000.0), 64),
                    exp_phi((k + 1) * 1000000.0, k * 1000000.0));
                if (k > 0) chk($sformatf("t2_spacing%0d", k), q_cyc[k] - q_cyc[k-1], 28);
            end
        end
        chk("t2_overrun", longint'(overrun), 0);

        // 3: ch1 overwritten while ch0 in flight; set beats clear
        do_reset();
        strobe(0, 2000000, 0, t0);
        tick(4);
        strobe(1, 3000000, 0, t1);
        chk("t3_no_ovr_first", longint'(overrun), 0);
        tick(4);
        sample_valid[1] = 1'b1;
        sin_v[1]        = 24'(0);
        cos_v[1]        = 24'(3000000);
        clear_overrun   = 1'b1;
        @(negedge clk);
        sample_valid  = '0;
        clear_overrun = 1'b0;
        chk("t3_ovr_set_wins", longint'(overrun), 2);
        clear_overrun = 1'b1;
        @(negedge clk);
        clear_overrun = 1'b0;
        chk("t3_ovr_cleared", longint'(overrun), 0);
        tick(70);
        chk("t3_count", q_ch.size(), 2);
        if (q_ch.size() == 2) begin
            chk("t3_ch0",     q_ch[0], 0);
            chk("t3_ch1",     q_ch[1], 1);
            chk("t3_lat1",    q_cyc[1] - t0, 57);
            chk("t3_phi_new", near(q_phi[1], exp_phi(0.0, 3000000.0), 64), exp_phi(0.0, 3000000.0));
            chk("t3_r_new",   near(q_r[1], exp_r(0.0, 3000000.0), 64), exp_r(0.0, 3000000.0));
        end

        // 4: ch3 re-strobes in its own grant cycle
        do_reset();
        strobe(3, 3000000, 0, t0);
        strobe(3, 0, 3000000, t1);
        tick(70);
        chk("t4_count", q_ch.size(), 2);
        if (q_ch.size() == 2) begin
            chk("t4_ch_a",    q_ch[0], 3);
            chk("t4_ch_b",    q_ch[1], 3);
            chk("t4_lat_a",   q_cyc[0] - t0, 29);
            chk("t4_spacing", q_cyc[1] - q_cyc[0], 28);
            chk("t4_phi_old", near(q_phi[0], exp_phi(3000000.0, 0.0), 64), exp_phi(3000000.0, 0.0));
            chk("t4_phi_new", near(q_phi[1], exp_phi(0.0, 3000000.0), 64), exp_phi(0.0, 3000000.0));
        end
        chk("t4_overrun", longint'(overrun), 0);

        // 5: negative x, both signs of y
        do_reset();
        strobe(0, -4000000, 1000, t0);
        tick(32);
        strobe(1, -4000000, -1000, t1);
        tick(35);
        chk("t5_count", q_ch.size(), 2);
        if (q_ch.size() == 2) begin
            chk("t5_phi_pos", near(q_phi[0], exp_phi(-4000000.0, 1000.0), 64), exp_phi(-4000000.0, 1000.0));
            chk("t5_r_pos",   near(q_r[0], exp_r(-4000000.0, 1000.0), 64), exp_r(-4000000.0, 1000.0));
            chk("t5_phi_neg", near(q_phi[1], exp_phi(-4000000.0, -1000.0), 64), exp_phi(-4000000.0, -1000.0));
            chk("t5_r_neg",   near(q_r[1], exp_r(-4000000.0, -1000.0), 64), exp_r(-4000000.0, -1000.0));
        end

        // 6: reset pulse while waiting on the core
        q_ch.delete();
        q_cyc.delete();
        q_phi.delete();
        q_r.delete();
        strobe(1, 3000000, 0, t0);
        tick(9);
        chk("t6_busy_before", longint'(busy), 1);
        reset_ni = 1'b0;
        #1;
        chk("t6_rst_busy",  longint'(busy), 0);
        chk("t6_rst_phi",   longint'(phi), 0);
        chk("t6_rst_r",     longint'(r), 0);
        chk("t6_rst_valid", longint'(result_valid), 0);
        @(negedge clk);
        reset_ni = 1'b1;
        tick(40);
        chk("t6_no_result", q_ch.size(), 0);
        strobe(2, 3000000, 0, t0);
        tick(35);
        chk("t6_after_count", q_ch.size(), 1);
        if (q_ch.size() == 1) begin
            chk("t6_after_ch",  q_ch[0], 2);
            chk("t6_after_lat", q_cyc[0] - t0, 29);
            chk("t6_after_r",   near(q_r[0], exp_r(3000000.0, 0.0), 64), exp_r(3000000.0, 0.0));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
